// File: rtl/mux_arb_pipe_pkg.sv
// Shared types and helpers for the mux_arb_pipe block.
//   MAX_N      : largest supported channel count
//   chan_idx_t : channel index wide enough for MAX_N channels
//   next_idx   : increment a channel index with wrap at n-1 -> 0
package mux_arb_pipe_pkg;

    localparam int MAX_N    = 16;
    localparam int MAX_SELW = $clog2(MAX_N);

    typedef logic [MAX_SELW-1:0] chan_idx_t;

    function automatic chan_idx_t next_idx(input chan_idx_t idx, input int unsigned n);
        return (int'(idx) == int'(n) - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/mux_arb_pipe_if.sv
// Producer/consumer bundle for mux_arb_pipe.
//   in_data   : N channels of WIDTH bits, channel i at bits [i*WIDTH +: WIDTH]
//   in_valid  : per-channel offer
//   in_ready  : per-channel accept (at most one bit set)
//   sel       : external channel select (used when RR==0)
//   out_data  : registered selected data
//   out_sel   : channel that produced out_data
//   out_valid : output register holds an item
//   out_ready : consumer accepts the held item
// master = producers + consumer side, slave = the mux itself.
interface mux_arb_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N-1:0][WIDTH-1:0] in_data;
    logic [N-1:0]            in_valid;
    logic [N-1:0]            in_ready;
    logic [SELW-1:0]         sel;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/mux_arb_pipe_rr_arbiter.sv
// Round-robin arbiter: picks the first requester starting at ptr_i and
// searching upward with wrap.
//   req_i     : per-channel request
//   ptr_i     : highest-priority channel this cycle
//   en_i      : when low, no grant is produced
//   grant_o   : one-hot grant (or zero)
//   gnt_idx_o : index of the granted channel (0 when none)
//   any_o     : a grant was produced
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            en_i,
    output logic [N-1:0]    grant_o,
    output logic [SELW-1:0] gnt_idx_o,
    output logic            any_o
);

    logic        found;
    int unsigned j;

    always_comb begin
        grant_o   = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            // ptr_i is always < N, so the modulo is a single wrap.
            j = (int'(ptr_i) + k) % N;
            if (en_i && !found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                gnt_idx_o  = SELW'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mux_arb_pipe.sv
// N:1 mux with per-channel valid/ready, a single registered output stage
// (latency 1, full throughput) and either external select (RR=0) or
// round-robin arbitration among valid channels (RR=1).
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : mux_arb_pipe_if slave modport (inputs, select, output handshake)
module mux_arb_pipe
    import mux_arb_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int RR    = 0
) (
    input  logic          clk,
    input  logic          rst,
    mux_arb_pipe_if.slave bus
);

    localparam int SELW = $clog2(N);

    logic [N-1:0]     grant;
    logic [SELW-1:0]  gnt_idx;
    logic             any;
    logic             load;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic [WIDTH-1:0] mux_data;

    // Output register can take a new item when empty or draining now.
    assign load = !out_valid_q || bus.out_ready;

    generate
        if (RR != 0) begin : g_rr
            rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
                .req_i     (bus.in_valid),
                .ptr_i     (ptr_q),
                .en_i      (rst),
                .grant_o   (grant),
                .gnt_idx_o (gnt_idx),
                .any_o     (any)
            );
        end else begin : g_sel
            // Compare against every legal index so sel >= N decodes to no grant.
            always_comb begin
                grant = '0;
                for (int i = 0; i < N; i++) begin
                    if (rst && bus.sel == SELW'(i) && bus.in_valid[i]) grant[i] = 1'b1;
                end
                gnt_idx = bus.sel;
                any     = |grant;
            end
        end
    endgenerate

    // One-hot AND-OR data select; avoids a variable part-select.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) mux_data = mux_data | bus.in_data[i];
        end
    end

    assign bus.in_ready = load ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = any;
            if (any) begin
                out_data_d = mux_data;
                out_sel_d  = gnt_idx;
                ptr_d      = SELW'(next_idx(chan_idx_t'(gnt_idx), N));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule
